// File: rtl/match_sequencer_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : match_sequencer_if                                               |
// | Purpose  : Start/goal inputs and score/clock/status outputs of the match    |
// |            sequencer, bundled with master (driver) and slave (DUT) views.   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface match_sequencer_if;
    logic       start_btn;
    logic       blue_score_tgl;
    logic       red_score_tgl;
    logic       game_initiated;
    logic       game_over;
    logic [3:0] blue_score;
    logic [3:0] red_score;
    logic [7:0] time_left;
    logic [1:0] winner;
    logic [2:0] phase;

    modport master (
        output start_btn, blue_score_tgl, red_score_tgl,
        input  game_initiated, game_over, blue_score, red_score,
               time_left, winner, phase
    );

    modport slave (
        input  start_btn, blue_score_tgl, red_score_tgl,
        output game_initiated, game_over, blue_score, red_score,
               time_left, winner, phase
    );
endinterface

`default_nettype wire

// File: rtl/match_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module   : match_sequencer                                                  |
// | Purpose  : Serves the ball, counts goals, runs the match clock and reports  |
// |            the winner. Optional macro GOLDEN_GOAL_EN enables sudden death.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module match_sequencer #(
    parameter int CLK_HZ        = 25_000_000,
    parameter int SERVE_DELAY   = 50_000_000,
    parameter int GOAL_PAUSE    = 75_000_000,
    parameter int WIN_SCORE     = 5,
    parameter int MATCH_SECONDS = 90
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    match_sequencer_if.slave   bus
);

    localparam int c_DLY_MAX = (SERVE_DELAY > GOAL_PAUSE) ? SERVE_DELAY : GOAL_PAUSE;
    localparam int c_DW      = (c_DLY_MAX > 1) ? $clog2(c_DLY_MAX) : 1;
    localparam int c_PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [c_DW-1:0] c_SERVE_LAST = c_DW'(SERVE_DELAY - 1);
    localparam logic [c_DW-1:0] c_PAUSE_LAST = c_DW'(GOAL_PAUSE - 1);
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(CLK_HZ - 1);
    localparam logic [3:0]      c_WIN        = 4'(WIN_SCORE);
    localparam logic [7:0]      c_MATCH      = 8'(MATCH_SECONDS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SERVE = 3'd1;
    localparam logic [2:0] c_PLAY  = 3'd2;
    localparam logic [2:0] c_PAUSE = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;

    logic [2:0]      r_state;
    logic [3:0]      r_blue;
    logic [3:0]      r_red;
    logic [7:0]      r_time;
    logic [c_PW-1:0] r_presc;
    logic [c_DW-1:0] r_delay;
    logic            r_blue_q;
    logic            r_red_q;
    logic            r_start_q;

    logic       w_in_play;
    logic       w_goal_b;
    logic       w_goal_r;
    logic       w_goal;
    logic       w_start;
    logic       w_restart;
    logic       w_tick;
    logic [3:0] w_blue_nxt;
    logic [3:0] w_red_nxt;
    logic [7:0] w_time_nxt;
    logic       w_win;
    logic       w_expired;
    logic       w_level;
    logic [2:0] w_state_nxt;

    // Goal edges only count while the ball is live
    assign w_in_play  = (r_state == c_PLAY);
    assign w_goal_b   = w_in_play & (bus.blue_score_tgl ^ r_blue_q);
    assign w_goal_r   = w_in_play & (bus.red_score_tgl ^ r_red_q);
    assign w_goal     = w_goal_b | w_goal_r;
    assign w_start    = bus.start_btn & ~r_start_q;
    assign w_restart  = w_start & ((r_state == c_IDLE) | (r_state == c_OVER));
    assign w_tick     = w_in_play & (r_presc == c_PRESC_LAST);

    assign w_blue_nxt = (w_goal_b && r_blue != 4'hF) ? r_blue + 4'd1 : r_blue;
    assign w_red_nxt  = (w_goal_r && r_red != 4'hF) ? r_red + 4'd1 : r_red;
    assign w_time_nxt = (w_tick && r_time != 8'd0) ? r_time - 8'd1 : r_time;

    assign w_win      = w_goal & ((w_blue_nxt >= c_WIN) | (w_red_nxt >= c_WIN));
    assign w_expired  = (w_time_nxt == 8'd0);
    assign w_level    = (w_blue_nxt == w_red_nxt);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) w_state_nxt = c_SERVE;
            end
            c_SERVE: begin
                if (r_delay == c_SERVE_LAST) w_state_nxt = c_PLAY;
            end
            c_PLAY: begin
                if (w_win) begin
                    w_state_nxt = c_OVER;
                end else if (w_expired) begin
`ifdef GOLDEN_GOAL_EN
                    // Level at zero time means sudden death: keep playing
                    if (!w_level) w_state_nxt = c_OVER;
`else
                    w_state_nxt = c_OVER;
`endif
                end else if (w_goal) begin
                    w_state_nxt = c_PAUSE;
                end
            end
            c_PAUSE: begin
                if (r_delay == c_PAUSE_LAST) w_state_nxt = c_SERVE;
            end
            c_OVER: begin
                if (w_start) w_state_nxt = c_SERVE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // History follows the inputs even in reset so no edge appears afterwards
        r_blue_q  <= bus.blue_score_tgl;
        r_red_q   <= bus.red_score_tgl;
        r_start_q <= bus.start_btn;

        if (!rst_n) begin
            r_state <= c_IDLE;
            r_blue  <= 4'd0;
            r_red   <= 4'd0;
            r_time  <= c_MATCH;
            r_presc <= '0;
            r_delay <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_restart) begin
                r_blue <= 4'd0;
                r_red  <= 4'd0;
                r_time <= c_MATCH;
            end else begin
                r_blue <= w_blue_nxt;
                r_red  <= w_red_nxt;
                r_time <= w_time_nxt;
            end

            if (w_in_play) begin
                r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            end

            if (r_state == c_SERVE) begin
                r_delay <= (r_delay == c_SERVE_LAST) ? '0 : r_delay + c_DW'(1);
            end else if (r_state == c_PAUSE) begin
                r_delay <= (r_delay == c_PAUSE_LAST) ? '0 : r_delay + c_DW'(1);
            end
        end
    end

    assign bus.game_initiated = (r_state == c_SERVE) && (r_delay == c_SERVE_LAST);
    assign bus.game_over      = (r_state == c_IDLE) || (r_state == c_OVER);
    assign bus.blue_score     = r_blue;
    assign bus.red_score      = r_red;
    assign bus.time_left      = r_time;
    assign bus.phase          = r_state;
    assign bus.winner         = (r_state != c_OVER) ? 2'b00 :
                                (r_blue > r_red)    ? 2'b01 :
                                (r_red > r_blue)    ? 2'b10 : 2'b11;

endmodule

`default_nettype wire
